// File: rtl/mul_ctrl_pkg.sv
// Shared types for the K-bit shift-multiplier sequencer: FSM state and step-count helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mul_step_counter.sv
// Step index counter: clear has priority over enable, tc flags index STEPS-1.
// Latency: cnt updates one cycle after en/clr; tc is a combinational decode of cnt.
// Backpressure: none; advances on every en cycle.
module mul_step_counter #(
  parameter int STEPS = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(STEPS - 1));

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the K-bit right-shift multiplier: load pulse, ceil(N/K) steps, done pulse.
// Latency: req accepted at edge t -> load t+1, steps t+2..t+STEPS+1, done t+STEPS+2.
// Backpressure: req ignored while busy (no queueing); MUL_EARLY_TERM_EN enables rem_zero early exit.
module mul_seq_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter  int N     = 16,
  parameter  int K     = 4,
  localparam int STEPS = ceil_div(N, K),
  localparam int CW    = $clog2(STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          is_signed,
  input  logic          rem_zero,
  output logic          busy,
  output logic          load,
  output logic          step_en,
  output logic          sign_step,
  output logic [CW-1:0] step_cnt,
  output logic          done
);

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          signed_flag;
  logic          last;
  logic          tc;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LOAD;
          accept    = 1'b1;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        // A request in the done cycle chains straight into the next load.
        if (req) begin
          state_nxt = LOAD;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      signed_flag <= 1'b0;
    end else if (accept) begin
      signed_flag <= is_signed;
    end
  end

  // Clearing on the last step leaves the index at zero for DONE and the next LOAD.
  mul_step_counter #(
    .STEPS (STEPS),
    .CW    (CW)
  ) u_step_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != RUN) | last),
    .en    (state == RUN),
    .cnt   (cnt),
    .tc    (tc)
  );

`ifdef MUL_EARLY_TERM_EN
  assign last = tc | rem_zero;
`else
  logic unused_rem_zero;
  assign unused_rem_zero = rem_zero;
  assign last = tc;
`endif

  assign load      = (state == LOAD);
  assign step_en   = (state == RUN);
  assign busy      = load | step_en;
  assign done      = (state == DONE);
  assign sign_step = step_en & signed_flag & last;
  assign step_cnt  = step_en ? cnt : '0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized bench for mul_seq_ctrl against a cycle-offset reference model.
// Three instances cover STEPS=4 (16/4), STEPS=3 (5/2) and STEPS=1 (8/8).
module tb_mul_seq_ctrl;

  localparam int N0 = 16, K0 = 4;
  localparam int N1 = 5,  K1 = 2;
  localparam int N2 = 8,  K2 = 8;
  localparam int S0 = (N0 + K0 - 1) / K0;
  localparam int S1 = (N1 + K1 - 1) / K1;
  localparam int S2 = (N2 + K2 - 1) / K2;
  localparam int CW0 = $clog2(S0 + 1);
  localparam int CW1 = $clog2(S1 + 1);
  localparam int CW2 = $clog2(S2 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [2:0]     req, is_signed, rem_zero;
  logic [2:0]     busy, load, step_en, sign_step, done;
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;
  logic [CW2-1:0] cnt2;

  int tests = 0;
  int fails = 0;

  mul_seq_ctrl #(.N(N0), .K(K0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .is_signed(is_signed[0]), .rem_zero(rem_zero[0]),
    .busy(busy[0]), .load(load[0]), .step_en(step_en[0]), .sign_step(sign_step[0]),
    .step_cnt(cnt0), .done(done[0]));

  mul_seq_ctrl #(.N(N1), .K(K1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .is_signed(is_signed[1]), .rem_zero(rem_zero[1]),
    .busy(busy[1]), .load(load[1]), .step_en(step_en[1]), .sign_step(sign_step[1]),
    .step_cnt(cnt1), .done(done[1]));

  mul_seq_ctrl #(.N(N2), .K(K2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req[2]), .is_signed(is_signed[2]), .rem_zero(rem_zero[2]),
    .busy(busy[2]), .load(load[2]), .step_en(step_en[2]), .sign_step(sign_step[2]),
    .step_cnt(cnt2), .done(done[2]));

  function automatic int nsteps(input int d);
    case (d)
      0:       return S0;
      1:       return S1;
      default: return S2;
    endcase
  endfunction

  // Observed outputs packed as {busy, load, step_en, sign_step, step_cnt[7:0], done}.
  function automatic logic [12:0] obs(input int d);
    logic [7:0] c;
    case (d)
      0:       c = 8'(cnt0);
      1:       c = 8'(cnt1);
      default: c = 8'(cnt2);
    endcase
    return {busy[d], load[d], step_en[d], sign_step[d], c, done[d]};
  endfunction

  function automatic logic [12:0] exp_vec(input bit ld, input bit run, input int cnt,
                                          input bit sg, input bit dn);
    return {ld | run, ld, run, sg, 8'(cnt), dn};
  endfunction

  // One operation on instance d; cycle j counts from the edge that accepts req.
  task automatic run_op(input int d, input bit sgn, input int early_at, input string name);
    int steps, eff;
    bit run;
    logic [12:0] got, exp;
    steps = nsteps(d);
    eff   = steps;
`ifdef MUL_EARLY_TERM_EN
    if (early_at >= 0 && early_at < steps - 1) eff = early_at + 1;
`endif
    @(negedge clk);
    req[d] = 1'b1; is_signed[d] = sgn; rem_zero[d] = 1'b0;
    for (int j = 1; j <= eff + 3; j++) begin
      @(negedge clk);
      req[d]       = (j <= eff + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      is_signed[d] = 1'($urandom_range(0, 1));
      rem_zero[d]  = (j - 2 == early_at);
      #1;
      run = (j >= 2 && j <= eff + 1);
      exp = exp_vec(j == 1, run, run ? j - 2 : 0, run && sgn && (j == eff + 1), j == eff + 2);
      got = obs(d);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s dut%0d cyc%0d got=%b required=%b", name, d, j, got, exp);
      end
    end
    req[d] = 1'b0; rem_zero[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; is_signed = '0; rem_zero = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (obs(d) !== 13'd0) begin
        fails++;
        $display("FAIL reset dut%0d got=%b required=0", d, obs(d));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    run_op(0, 1'b0, -1, "unsigned_16_4");
  endtask

  task automatic test_signed();
    run_op(0, 1'b1, -1, "signed_16_4");
  endtask

  task automatic test_small_configs();
    run_op(1, 1'b0, -1, "unsigned_5_2");
    run_op(1, 1'b1, -1, "signed_5_2");
    run_op(2, 1'b0, -1, "unsigned_8_8");
    run_op(2, 1'b1, -1, "signed_8_8");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    req[0] = 1'b1; is_signed[0] = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      req[0] = 1'b0;
    end
    #1;
    tests++;
    if (obs(0) !== exp_vec(0, 1, 2, 0, 0)) begin
      fails++;
      $display("FAIL midrun_pre dut0 got=%b required=%b", obs(0), exp_vec(0, 1, 2, 0, 0));
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (obs(0) !== 13'd0) begin
      fails++;
      $display("FAIL midrun_reset dut0 got=%b required=0", obs(0));
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (obs(0) !== 13'd0) begin
      fails++;
      $display("FAIL midrun_nodone dut0 got=%b required=0", obs(0));
    end
    run_op(0, 1'b1, -1, "after_reset");
  endtask

  // req held high: a new op every STEPS+2 cycles, requests during busy ignored.
  task automatic test_back_to_back(input int d);
    int p, m;
    bit sgn;
    logic [12:0] exp;
    p   = nsteps(d) + 2;
    sgn = 1'($urandom_range(0, 1));
    @(negedge clk);
    req[d] = 1'b1; is_signed[d] = sgn;
    for (int j = 1; j <= 3 * p + 1; j++) begin
      @(negedge clk);
      req[d] = (j < 3 * p) ? 1'b1 : 1'b0;
      #1;
      m = j % p;
      if (j > 3 * p) exp = 13'd0;
      else exp = exp_vec(m == 1, m >= 2, (m >= 2) ? m - 2 : 0, sgn && (m == p - 1), m == 0);
      tests++;
      if (obs(d) !== exp) begin
        fails++;
        $display("FAIL back_to_back dut%0d cyc%0d got=%b required=%b", d, j, obs(d), exp);
      end
    end
  endtask

  task automatic test_early_term();
    run_op(0, 1'b1, 1, "early_term_step1");
    run_op(0, 1'b0, 0, "early_term_step0");
    run_op(1, 1'b1, 1, "early_term_5_2");
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, nsteps(d))) - 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_small_configs();
    test_reset_mid_run();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    test_early_term();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
